lz77_decoder: RTL
=================

Name: lz77_decoder

Overview:
- Decodes the (offset, match_len, char_nxt) triple stream produced by the team's LZ77 encoder and rebuilds the original byte string.
- Keeps a 9-byte search buffer of the most recently emitted characters.
- Each accepted triple produces match_len copied bytes followed by one literal byte, one byte per cycle.
- Sits downstream of the encoder output or a code FIFO; feeds the byte sink and scoreboard.

Parameters:
- SEARCH_DEPTH, 9, number of search-buffer entries; valid offsets are 0..SEARCH_DEPTH-1.
- OFF_W, 4, code_pos width.
- LEN_W, 3, code_len width; max copy length is 7.
- END_CHAR, 8'h24, terminator literal ('$').

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- code_valid  input  1  triple present on code_pos/code_len/chardata.
- code_ready  output  1  decoder can accept a triple this cycle.
- code_pos  input  OFF_W  copy offset; 0 = most recently emitted byte.
- code_len  input  LEN_W  number of bytes to copy.
- chardata  input  8  literal byte following the copy.
- encode  output  1  mode flag; constant 0 (decode mode).
- char_valid  output  1  char_nxt holds a decoded byte this cycle.
- char_nxt  output  8  decoded byte.
- finish  output  1  END_CHAR literal consumed; sticky until reset.

Behaviour:
- Reset (async, any state, including mid-copy):
  - state=WAIT; code_ready=1; char_valid=0; char_nxt=8'h00; finish=0; encode=0.
  - Internal counters cleared; all search-buffer entries 8'h00.
- Handshake: a triple is accepted on a rising edge where code_valid && code_ready. pos, len and char are latched at that edge. code_ready = (state==WAIT). Inputs are ignored when code_ready=0.
- States:
  - WAIT: on accept, go to COPY with cnt=len if len!=0; otherwise go to LIT.
  - COPY: each edge registers char_nxt=buf[pos] and char_valid=1, shifts that byte into buf[0] (buf[i+1]<=buf[i], oldest dropped), and decrements cnt. At cnt==1 go to LIT.
  - LIT, literal != END_CHAR: register char_nxt=char and char_valid=1, shift char into buf[0], go to WAIT.
  - LIT, literal == END_CHAR: char_valid=0, char_nxt held, buffer unchanged, go to DONE.
  - DONE: finish=1, code_ready=0, char_valid=0; stays in DONE until reset.
- In every cycle where the registered state does not emit, char_valid=0 and char_nxt holds its last value.
- Overlapping copy (len > pos): the read index stays constant while the buffer shifts, so runs regenerate correctly.
- Timing:
  - Accept at edge E; first byte is registered at edge E+1.
  - len+1 consecutive char_valid cycles, or len cycles if the literal is END_CHAR.
  - code_ready is high again in the cycle the literal is presented, giving len+2 cycles per triple back to back.
- finish rises on the edge after the LIT state that sees END_CHAR.
- Out-of-range pos (>= SEARCH_DEPTH): the copy reads 8'h00.
- Reads of never-written entries return 8'h00.

Optional Feature:
- Macro LZ77_DEC_CHECK_EN.
- When defined:
  - Adds output err (1 bit, reset 0, sticky until reset).
  - err sets on accept when pos >= SEARCH_DEPTH.
  - err sets on accept when len!=0 and pos >= number of bytes emitted so far (fill counter saturating at SEARCH_DEPTH).
  - Decoding proceeds unchanged.
- When undefined: no err port, no fill counter, identical data behaviour.

Test Plan:
- Reset check: assert reset for 2 cycles, then release -> code_ready=1, char_valid=0, char_nxt=00, finish=0, encode=0.
- Single literal: after reset, triple (0,0,'A') -> next cycle char_valid=1, char_nxt=41; code_ready=0 only during the WAIT->LIT transition cycle.
- Overlap copy: after emitting 'A','B', triple (1,4,'C') -> char_nxt sequence 41 42 41 42 43 over 5 consecutive valid cycles.
- Run length: after 'a', triple (0,7,'b') -> seven 61 bytes then 62; 8 valid cycles, no gaps.
- Termination: after "xy", triple (0,2,'$') -> 79 79, then char_valid=0 and finish=1 from the following cycle. A further code_valid=1 is ignored: code_ready=0, no output.
- Reset mid-copy: assert reset during COPY of (0,7,'z') -> outputs return to reset values immediately. Next triple (3,1,'q') emits 00 71 (buffer cleared); with LZ77_DEC_CHECK_EN, err=1.

Source files
------------

// File: rtl/lz77_decoder.sv
// LZ77 triple decoder: rebuilds the byte stream from (offset, length, literal) codes using a shifting search buffer.
// Optional `LZ77_DEC_CHECK_EN adds a sticky err flag for offsets that point past the filled part of the buffer.
module lz77_decoder #(
   parameter int           SEARCH_DEPTH = 9,
   parameter int           OFF_W        = 4,
   parameter int           LEN_W        = 3,
   parameter logic [7:0]   END_CHAR     = 8'h24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             code_valid,
   output logic             code_ready,
   input  logic [OFF_W-1:0] code_pos,
   input  logic [LEN_W-1:0] code_len,
   input  logic [7:0]       chardata,
   output logic             encode,
   output logic             char_valid,
   output logic [7:0]       char_nxt,
`ifdef LZ77_DEC_CHECK_EN
   output logic             err,
`endif
   output logic             finish
);

   typedef enum logic [1:0] {WAIT, COPY, LIT, DONE} state_t;

   localparam logic [OFF_W-1:0] DEPTH_OFF = OFF_W'(SEARCH_DEPTH);

   state_t           state;
   state_t           state_next;
   logic [OFF_W-1:0] pos_q;
   logic [LEN_W-1:0] cnt_q;
   logic [7:0]       lit_q;
   logic [7:0]       sbuf [SEARCH_DEPTH];
   logic [7:0]       rd_byte;
   logic [7:0]       emit_byte;
   logic             accept;
   logic             emit;

   assign encode     = 1'b0;
   assign code_ready = (state == WAIT);
   assign finish     = (state == DONE);
   assign accept     = code_valid && code_ready;

   // Entries beyond the buffer depth read as zero, same as never-written ones.
   always_comb begin
      rd_byte = 8'h00;
      for (int i = 0; i < SEARCH_DEPTH; i++) begin
         if (pos_q == OFF_W'(i)) rd_byte = sbuf[i];
      end
   end

   always_comb begin
      emit      = 1'b0;
      emit_byte = lit_q;
      case (state)
         COPY: begin
            emit      = 1'b1;
            emit_byte = rd_byte;
         end
         LIT:     emit = (lit_q != END_CHAR);
         default: emit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= WAIT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         WAIT: begin
            if (code_valid) state_next = (code_len != '0) ? COPY : LIT;
         end
         COPY: begin
            if (cnt_q == LEN_W'(1)) state_next = LIT;
         end
         LIT:     state_next = (lit_q == END_CHAR) ? DONE : WAIT;
         DONE:    state_next = DONE;
         default: state_next = WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_q      <= '0;
         cnt_q      <= '0;
         lit_q      <= 8'h00;
         char_valid <= 1'b0;
         char_nxt   <= 8'h00;
      end else begin
         char_valid <= emit;
         if (accept) begin
            pos_q <= code_pos;
            cnt_q <= code_len;
            lit_q <= chardata;
         end
         if (emit) char_nxt <= emit_byte;
         if (state == COPY) cnt_q <= cnt_q - LEN_W'(1);
      end
   end

   // The read index is fixed while the buffer shifts, so overlapping copies replay the run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SEARCH_DEPTH; i++) sbuf[i] <= 8'h00;
      end else if (emit) begin
         for (int i = SEARCH_DEPTH - 1; i > 0; i--) sbuf[i] <= sbuf[i-1];
         sbuf[0] <= emit_byte;
      end
   end

`ifdef LZ77_DEC_CHECK_EN
   localparam logic [OFF_W:0] DEPTH_FILL = (OFF_W+1)'(SEARCH_DEPTH);

   logic [OFF_W:0] fill_q;
   logic           bad_code;

   assign bad_code = (code_pos >= DEPTH_OFF) ||
                     ((code_len != '0) && ({1'b0, code_pos} >= fill_q));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_q <= '0;
         err    <= 1'b0;
      end else begin
         if (emit && (fill_q < DEPTH_FILL)) fill_q <= fill_q + 1'b1;
         if (accept && bad_code)            err    <= 1'b1;
      end
   end
`else
   logic unused_depth;
   assign unused_depth = &DEPTH_OFF;
`endif

endmodule
